// File: rtl/conv_seq_ctrl_if.sv
// rtl/conv_seq_ctrl_if.sv - host/Conv/BRAM control bundle for conv_seq_ctrl
//
// Purpose: groups the start/length request and every sequencer output into one bundle.
// Ports (signals):
//   i_start, i_img_len            host request (driven by master)
//   o_conv_reset, o_selecK_I,
//   o_valid, o_ker_sel            Conv control
//   o_read_addr, o_write_addr,
//   o_wr_enable, o_car_conv       BRAM control
//   o_busy, o_done, o_error       job status
// Modports: master = host side, slave = sequencer side.
interface conv_seq_ctrl_if #(
  parameter int NB_ADDRESS = 10
);
  logic                  i_start;
  logic [NB_ADDRESS-1:0] i_img_len;
  logic                  o_conv_reset;
  logic                  o_selecK_I;
  logic                  o_valid;
  logic [1:0]            o_ker_sel;
  logic [NB_ADDRESS-1:0] o_read_addr;
  logic [NB_ADDRESS-1:0] o_write_addr;
  logic                  o_wr_enable;
  logic                  o_car_conv;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_error;

  modport master (
    output i_start, i_img_len,
    input  o_conv_reset, o_selecK_I, o_valid, o_ker_sel,
    input  o_read_addr, o_write_addr, o_wr_enable, o_car_conv,
    input  o_busy, o_done, o_error
  );

  modport slave (
    input  i_start, i_img_len,
    output o_conv_reset, o_selecK_I, o_valid, o_ker_sel,
    output o_read_addr, o_write_addr, o_wr_enable, o_car_conv,
    output o_busy, o_done, o_error
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - start/done sequencer for the 3x3 Conv fed by column BRAM banks
//
// Purpose: walks the Conv through kernel load, a one-cycle gap, image column
// streaming and a drain, writing each window result back into bank 0.
// Ports:
//   CLK100MHZ  rising-edge system clock
//   i_reset    asynchronous active-low reset
//   bus        conv_seq_ctrl_if.slave
//                in : i_start, i_img_len (N columns, sampled with i_start in IDLE)
//                out: Conv controls (o_conv_reset, o_selecK_I, o_valid, o_ker_sel),
//                     BRAM controls (o_read_addr, o_write_addr, o_wr_enable, o_car_conv),
//                     status (o_busy, o_done, o_error)
module conv_seq_ctrl #(
  parameter int NB_ADDRESS = 10,
  parameter int MEM_LAT    = 1,
  parameter int CONV_LAT   = 2,
  parameter int M_LEN      = 3
) (
  input logic            CLK100MHZ,
  input logic            i_reset,
  conv_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_K = 3'd1,
    GAP    = 3'd2,
    FEED   = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [NB_ADDRESS-1:0] n_q, n_d;
  logic [1:0]            ker_q, ker_d;
  logic [NB_ADDRESS-1:0] rd_addr_q, rd_addr_d;
  logic [NB_ADDRESS-1:0] pres_q, pres_d;
  logic [NB_ADDRESS-1:0] wr_addr_q, wr_addr_d;
  logic [MEM_LAT-1:0]    vld_q, vld_d;
  logic [CONV_LAT-1:0]   tok_q, tok_d;
  logic                  err_q, err_d;

  logic                  img_valid;
  logic                  push;
  logic                  wr_fire;
  logic                  conv_reset;
  logic                  selk;
  logic                  valid;
  logic [1:0]            ker_sel;
  logic                  car_conv;
  logic                  busy;
  logic                  done;

  // A column read issued in FEED reaches the Conv MEM_LAT cycles later.
  assign img_valid = vld_q[MEM_LAT-1];

  // The first M_LEN-1 presented columns only prime the window; every later
  // column completes a window and produces one result.
  assign push = img_valid && (pres_q >= NB_ADDRESS'(M_LEN - 1));

  // A result token emerges from the Conv pipeline CONV_LAT cycles after push.
  assign wr_fire = tok_q[CONV_LAT-1];

  // Read-valid and result-token delay lines, both shifting every cycle.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = (state_q == FEED);
    for (int i = 1; i < MEM_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    tok_d    = '0;
    tok_d[0] = push;
    for (int i = 1; i < CONV_LAT; i++) begin
      tok_d[i] = tok_q[i-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    ker_d      = ker_q;
    rd_addr_d  = rd_addr_q;
    pres_d     = img_valid ? pres_q + NB_ADDRESS'(1) : pres_q;
    wr_addr_d  = wr_fire ? wr_addr_q + NB_ADDRESS'(1) : wr_addr_q;
    err_d      = 1'b0;
    conv_reset = 1'b0;
    selk       = 1'b1;
    valid      = img_valid;
    ker_sel    = 2'd0;
    car_conv   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        conv_reset = 1'b1;
        selk       = 1'b0;
        valid      = 1'b0;
        busy       = 1'b0;
        ker_d      = 2'd0;
        rd_addr_d  = '0;
        pres_d     = '0;
        wr_addr_d  = '0;
        if (bus.i_start) begin
          if (bus.i_img_len >= NB_ADDRESS'(M_LEN)) begin
            n_d     = bus.i_img_len;
            state_d = LOAD_K;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD_K: begin
        selk    = 1'b0;
        valid   = 1'b1;
        ker_sel = ker_q;
        ker_d   = ker_q + 2'd1;
        if (ker_q == 2'(M_LEN - 1)) begin
          state_d = GAP;
        end
      end

      GAP: begin
        state_d = FEED;
      end

      FEED: begin
        car_conv = 1'b1;
        if (rd_addr_q == n_q - NB_ADDRESS'(1)) begin
          state_d = DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + NB_ADDRESS'(1);
        end
      end

      DRAIN: begin
        car_conv = 1'b1;
        // The write counter reaching N-(M_LEN-1) means the final write has
        // retired; the pipeline checks keep this robust for any latency.
        if ((wr_addr_q == n_q - NB_ADDRESS'(M_LEN - 1)) &&
            (tok_q == '0) && !img_valid) begin
          done      = 1'b1;
          busy      = 1'b0;
          car_conv  = 1'b0;
          rd_addr_d = '0;
          pres_d    = '0;
          wr_addr_d = '0;
          ker_d     = 2'd0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      n_q       <= '0;
      ker_q     <= 2'd0;
      rd_addr_q <= '0;
      pres_q    <= '0;
      wr_addr_q <= '0;
      vld_q     <= '0;
      tok_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      ker_q     <= ker_d;
      rd_addr_q <= rd_addr_d;
      pres_q    <= pres_d;
      wr_addr_q <= wr_addr_d;
      vld_q     <= vld_d;
      tok_q     <= tok_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_conv_reset = conv_reset;
  assign bus.o_selecK_I   = selk;
  assign bus.o_valid      = valid;
  assign bus.o_ker_sel    = ker_sel;
  assign bus.o_read_addr  = rd_addr_q;
  assign bus.o_write_addr = wr_addr_q;
  assign bus.o_wr_enable  = wr_fire;
  assign bus.o_car_conv   = car_conv;
  assign bus.o_busy       = busy;
  assign bus.o_done       = done;
  assign bus.o_error      = err_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb/tb_conv_seq_ctrl.sv - randomized model-checked bench for conv_seq_ctrl (CONV_LAT 2 and 4)
module tb_conv_seq_ctrl;
  localparam int NB  = 10;
  localparam int ML  = 1;
  localparam int CL0 = 2;
  localparam int CL1 = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NB-1:0] len   = '0;
  int            cyc   = 0;
  int            pass_cnt  = 0;
  int            total_cnt = 0;

  always #5 clk = ~clk;

  conv_seq_ctrl_if #(.NB_ADDRESS(NB)) bus0 ();
  conv_seq_ctrl_if #(.NB_ADDRESS(NB)) bus1 ();
  assign bus0.i_start   = start;
  assign bus0.i_img_len = len;
  assign bus1.i_start   = start;
  assign bus1.i_img_len = len;

  conv_seq_ctrl #(.NB_ADDRESS(NB), .MEM_LAT(ML), .CONV_LAT(CL0), .M_LEN(3)) dut0 (
    .CLK100MHZ(clk), .i_reset(rst_n), .bus(bus0));
  conv_seq_ctrl #(.NB_ADDRESS(NB), .MEM_LAT(ML), .CONV_LAT(CL1), .M_LEN(3)) dut1 (
    .CLK100MHZ(clk), .i_reset(rst_n), .bus(bus1));

  typedef struct {
    bit cr, sk, v, we, cc, busy, done;
    bit ck_ks, ck_ra, ck_wa;
    int ks, ra, wa;
  } exp_t;

  // Expected outputs at cycle offset t after the start was sampled, from the job timeline.
  function automatic exp_t model(input bit active, input int t, input int n, input int cl);
    exp_t e;
    int   td;
    int   k;
    e       = '{default: 0};
    e.cr    = 1;
    e.ck_ra = 1;
    e.ck_wa = 1;
    td = 5 + ML + cl + n;
    if (!active || t <= 0 || t > td) return e;
    e.cr    = 0;
    e.busy  = 1;
    e.ck_wa = 0;
    if (t <= 3) begin
      e.v = 1; e.ks = t - 1; e.ck_ks = 1; e.ra = 0;
      return e;
    end
    e.sk = 1;
    if (t == 4) begin
      e.ra = 0;
      return e;
    end
    e.ra = (t - 5 < n - 1) ? t - 5 : n - 1;
    if (t == td) begin
      e.busy = 0; e.done = 1; e.ck_ra = 0;
      return e;
    end
    e.cc = 1;
    e.v  = (t - 5 - ML >= 0) && (t - 5 - ML <= n - 1);
    k = t - 7 - ML - cl;
    if (k >= 0 && k <= n - 3) begin
      e.we = 1; e.wa = k; e.ck_wa = 1;
    end
    return e;
  endfunction

  bit act[2]  = '{0, 0};
  int js[2]   = '{0, 0};
  int jn[2]   = '{0, 0};
  int ecyc[2] = '{-1, -1};

  function automatic int cl_of(input int d);
    return (d == 0) ? CL0 : CL1;
  endfunction

  function automatic bit m_idle(input int d, input int c);
    return !act[d] || (c - js[d] > 5 + ML + cl_of(d) + jn[d]);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        act[d]  <= 0;
        ecyc[d] <= -1;
      end else if (start && m_idle(d, cyc)) begin
        if (int'(len) >= 3) begin
          act[d] <= 1;
          js[d]  <= cyc;
          jn[d]  <= int'(len);
        end else begin
          ecyc[d] <= cyc + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int actv, input int expv);
    total_cnt++;
    if (actv == expv) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, actv, expv, cyc);
  endtask

  task automatic cmp(input int d, input logic cr, input logic sk, input logic v,
                     input logic [1:0] ks, input logic [NB-1:0] ra, input logic we,
                     input logic [NB-1:0] wa, input logic cc, input logic busy,
                     input logic done, input logic err);
    exp_t e;
    e = model(rst_n && act[d], cyc - js[d], jn[d], cl_of(d));
    chk($sformatf("d%0d_conv_reset", d), int'(cr), int'(e.cr));
    chk($sformatf("d%0d_selecK_I", d), int'(sk), int'(e.sk));
    chk($sformatf("d%0d_valid", d), int'(v), int'(e.v));
    chk($sformatf("d%0d_wr_enable", d), int'(we), int'(e.we));
    chk($sformatf("d%0d_car_conv", d), int'(cc), int'(e.cc));
    chk($sformatf("d%0d_busy", d), int'(busy), int'(e.busy));
    chk($sformatf("d%0d_done", d), int'(done), int'(e.done));
    chk($sformatf("d%0d_error", d), int'(err), int'(rst_n && (cyc == ecyc[d])));
    if (e.ck_ks) chk($sformatf("d%0d_ker_sel", d), int'(ks), e.ks);
    if (e.ck_ra) chk($sformatf("d%0d_read_addr", d), int'(ra), e.ra);
    if (e.ck_wa) chk($sformatf("d%0d_write_addr", d), int'(wa), e.wa);
  endtask

  always @(negedge clk) begin
    cmp(0, bus0.o_conv_reset, bus0.o_selecK_I, bus0.o_valid, bus0.o_ker_sel,
        bus0.o_read_addr, bus0.o_wr_enable, bus0.o_write_addr, bus0.o_car_conv,
        bus0.o_busy, bus0.o_done, bus0.o_error);
    cmp(1, bus1.o_conv_reset, bus1.o_selecK_I, bus1.o_valid, bus1.o_ker_sel,
        bus1.o_read_addr, bus1.o_wr_enable, bus1.o_write_addr, bus1.o_car_conv,
        bus1.o_busy, bus1.o_done, bus1.o_error);
  end

  // One job: start with n, optionally poke start (len poke_len) or reset at offset poke_t.
  task automatic run_job(input int n, input int poke_t, input bit poke_rst, input int poke_len,
                         output int w0, output int w1, output int f0, output int f1,
                         output int dn, output int er);
    int s;
    int o;
    w0 = 0; w1 = 0; f0 = -1; f1 = -1; dn = -1; er = 0;
    @(posedge clk); #1;
    s = cyc; start = 1'b1; len = NB'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      o = cyc - s;
      if (o == poke_t) begin
        if (poke_rst) begin
          rst_n = 1'b0;
          #1;
          chk("reset_wr_enable", int'(bus0.o_wr_enable), 0);
          chk("reset_conv_reset", int'(bus0.o_conv_reset), 1);
        end else begin
          start = 1'b1; len = NB'(poke_len);
        end
      end else if (o == poke_t + 1) begin
        rst_n = 1'b1; start = 1'b0;
      end
      if (bus0.o_wr_enable) begin w0++; if (f0 < 0) f0 = o; end
      if (bus1.o_wr_enable) begin w1++; if (f1 < 0) f1 = o; end
      if (bus0.o_done) dn = o;
      if (bus0.o_error) er++;
      if (m_idle(0, cyc) && m_idle(1, cyc)) break;
      @(posedge clk); #1;
    end
    chk("job_completes", int'(m_idle(0, cyc) && m_idle(1, cyc)), 1);
    start = 1'b0;
    if (!rst_n) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
  endtask

  initial begin
    exp_t e;
    int w0, w1, f0, f1, dn, er;
    int dn_cnt, wsum, hold;

    @(posedge clk); #1;
    chk("rst_conv_reset", int'(bus0.o_conv_reset), 1);
    chk("rst_busy", int'(bus0.o_busy), 0);
    chk("rst_wr_enable", int'(bus0.o_wr_enable), 0);
    chk("rst_valid", int'(bus1.o_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    e = model(1, 10, 16, 2);
    chk("model_first_wr", int'(e.we), 1);
    chk("model_first_wa", e.wa, 0);
    e = model(1, 23, 16, 2);
    chk("model_last_wa", e.wa, 13);
    e = model(1, 24, 16, 2);
    chk("model_done", int'(e.done), 1);
    e = model(1, 12, 8, 4);
    chk("model_cl4_first_wr", int'(e.we), 1);
    e = model(1, 3, 16, 2);
    chk("model_ker_sel2", e.ks, 2);

    run_job(16, -5, 0, 0, w0, w1, f0, f1, dn, er);
    chk("n16_writes_cl2", w0, 14);
    chk("n16_writes_cl4", w1, 14);
    chk("n16_first_wr_cl2", f0, 10);
    chk("n16_first_wr_cl4", f1, 12);
    chk("n16_done_cycle", dn, 24);

    run_job(3, -5, 0, 0, w0, w1, f0, f1, dn, er);
    chk("n3_writes", w0, 1);
    chk("n3_done_cycle", dn, 11);

    run_job(2, -5, 0, 0, w0, w1, f0, f1, dn, er);
    chk("n2_error", er, 1);
    chk("n2_writes", w0, 0);
    run_job(0, -5, 0, 0, w0, w1, f0, f1, dn, er);
    chk("n0_error", er, 1);

    run_job(8, -5, 0, 0, w0, w1, f0, f1, dn, er);
    chk("n8_writes_cl4", w1, 6);
    chk("n8_first_wr_cl4", f1, 12);

    run_job(10, 8, 0, 3, w0, w1, f0, f1, dn, er);
    chk("feed_start_ignored_writes", w0, 8);
    chk("feed_start_ignored_done", dn, 18);

    // Start held across the done cycle (ignored) into the first IDLE cycle (accepted).
    @(posedge clk); #1;
    start = 1'b1; len = NB'(5);
    @(posedge clk); #1;
    start = 1'b0;
    dn_cnt = 0; wsum = 0; hold = 0;
    for (int i = 0; i < 200; i++) begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) start = 1'b0;
      end
      if (bus0.o_wr_enable) wsum++;
      if (bus0.o_done) begin
        dn_cnt++;
        if (dn_cnt == 1) begin start = 1'b1; len = NB'(4); hold = 2; end
      end
      if (dn_cnt == 2 && m_idle(0, cyc) && m_idle(1, cyc)) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("b2b_done_pulses", dn_cnt, 2);
    chk("b2b_writes", wsum, 5);

    run_job(10, 12, 1, 0, w0, w1, f0, f1, dn, er);
    chk("midreset_writes", w0, 2);
    chk("midreset_no_done", dn, -1);
    run_job(6, -5, 0, 0, w0, w1, f0, f1, dn, er);
    chk("after_reset_writes", w0, 4);

    run_job(1023, -5, 0, 0, w0, w1, f0, f1, dn, er);
    chk("nmax_writes", w0, 1021);

    for (int it = 0; it < 30; it++) begin
      run_job(int'($urandom_range(0, 24)),
              ($urandom_range(0, 2) == 0) ? -5 : int'($urandom_range(1, 40)),
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, 20)),
              w0, w1, f0, f1, dn, er);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
